// File: rtl/grid_link_router.sv
// grid_link_router: merges the parent and grid inbound links round-robin
// into one handler stream, and steers handler words to parent/grid links.
// Ports: clk, reset (sync, active-high); local_tx_* handler->router;
// local_rx_* router->handler; parent_rx_*/parent_tx_* parent link;
// grid_in_*/grid_out_* packed neighbour links (link k at slice k);
// router_busy = any FIFO non-empty or any output register valid.
// Optional: define GRID_ROUTER_BROADCAST_EN to replicate dest=all-ones
// words to the parent and every grid link.
module grid_link_router #(
    parameter int NUM_GRID_LINKS = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int FIFO_DEPTH     = 8,
    parameter int DEST_WIDTH     = 8,
    parameter logic [DEST_WIDTH-1:0] FPGA_ID = 1,
    parameter logic [NUM_GRID_LINKS*DEST_WIDTH-1:0] GRID_DEST_IDS =
        {8'd3, 8'd2}
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                local_tx_data,
    input  logic                                 local_tx_valid,
    output logic                                 local_tx_ready,
    output logic [DATA_WIDTH-1:0]                local_rx_data,
    output logic                                 local_rx_valid,
    input  logic                                 local_rx_ready,
    input  logic [DATA_WIDTH-1:0]                parent_rx_data,
    input  logic                                 parent_rx_valid,
    output logic                                 parent_rx_ready,
    output logic [DATA_WIDTH-1:0]                parent_tx_data,
    output logic                                 parent_tx_valid,
    input  logic                                 parent_tx_ready,
    input  logic [NUM_GRID_LINKS*DATA_WIDTH-1:0] grid_in_data,
    input  logic [NUM_GRID_LINKS-1:0]            grid_in_valid,
    output logic [NUM_GRID_LINKS-1:0]            grid_in_ready,
    output logic [NUM_GRID_LINKS*DATA_WIDTH-1:0] grid_out_data,
    output logic [NUM_GRID_LINKS-1:0]            grid_out_valid,
    input  logic [NUM_GRID_LINKS-1:0]            grid_out_ready,
    output logic                                 router_busy
);

    localparam int NS = NUM_GRID_LINKS + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(NS);

    typedef enum logic [0:0] {S_IDLE, S_BCAST} state_t;

    // Source/link index 0 is the parent, k+1 is grid link k.
    logic [DATA_WIDTH-1:0] w_in_data [NS];
    logic [NS-1:0]         w_in_valid;
    logic [NS-1:0]         w_in_ready;
    logic [NS-1:0]         w_push;
    logic [NS-1:0]         w_pop;
    logic [NS-1:0]         w_ne_nxt;
    logic [CW-1:0]         w_cnt_nxt [NS];

    logic [DATA_WIDTH-1:0] r_mem [NS][FIFO_DEPTH];
    logic [AW-1:0]         r_wp [NS];
    logic [AW-1:0]         r_rp [NS];
    logic [CW-1:0]         r_cnt [NS];

    logic                  r_rx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [SW-1:0]         r_ptr;
    logic                  w_load;
    logic                  w_gnt_vld;
    logic [SW-1:0]         w_gnt;
    logic                  w_rx_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rx_data_nxt;
    logic [SW-1:0]         w_ptr_nxt;

    logic [NS-1:0]         r_ov;
    logic [DATA_WIDTH-1:0] r_od [NS];
    logic [NS-1:0]         w_oready;
    logic [NS-1:0]         w_can;
    logic [NS-1:0]         w_ld;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [NS-1:0]         w_ov_nxt;
    logic [DATA_WIDTH-1:0] w_od_nxt [NS];

    logic [DEST_WIDTH-1:0] w_dest;
    logic                  w_hit;
    logic [SW-1:0]         w_tgt;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;

`ifdef GRID_ROUTER_BROADCAST_EN
    logic [NS-1:0]         r_mask;
    logic [NS-1:0]         w_mask_nxt;
    logic [DATA_WIDTH-1:0] r_bdata;
    logic [DATA_WIDTH-1:0] w_bdata_nxt;
`endif

    // Link packing.
    always_comb begin
        w_in_data[0]    = parent_rx_data;
        w_in_valid[0]   = parent_rx_valid;
        w_oready[0]     = parent_tx_ready;
        parent_rx_ready = w_in_ready[0];
        parent_tx_data  = r_od[0];
        parent_tx_valid = r_ov[0];
        grid_in_ready   = '0;
        grid_out_data   = '0;
        grid_out_valid  = '0;
        for (int k = 0; k < NUM_GRID_LINKS; k++) begin
            w_in_data[k+1]  = grid_in_data[k*DATA_WIDTH +: DATA_WIDTH];
            w_in_valid[k+1] = grid_in_valid[k];
            w_oready[k+1]   = grid_out_ready[k];
            grid_in_ready[k] = w_in_ready[k+1];
            grid_out_data[k*DATA_WIDTH +: DATA_WIDTH] = r_od[k+1];
            grid_out_valid[k] = r_ov[k+1];
        end
    end

    // Round-robin search starts at r_ptr (the source after the last grant).
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int i = 0; i < NS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NS) idx = idx - NS;
            if (!w_gnt_vld && r_cnt[idx] != '0) begin
                w_gnt_vld = 1'b1;
                w_gnt     = SW'(idx);
            end
        end
    end

    always_comb begin
        w_load         = !r_rx_valid || local_rx_ready;
        w_rx_valid_nxt = r_rx_valid && !local_rx_ready;
        w_rx_data_nxt  = r_rx_data;
        w_ptr_nxt      = r_ptr;
        if (w_load) begin
            w_rx_valid_nxt = w_gnt_vld;
            if (w_gnt_vld) begin
                w_rx_data_nxt = r_mem[w_gnt][r_rp[w_gnt]];
                w_ptr_nxt = (w_gnt == SW'(NS - 1)) ? '0 : w_gnt + 1'b1;
            end
        end
        for (int s = 0; s < NS; s++) begin
            w_in_ready[s] = (r_cnt[s] != CW'(FIFO_DEPTH));
            w_push[s]     = w_in_valid[s] && w_in_ready[s];
            w_pop[s]      = w_load && w_gnt_vld && (w_gnt == SW'(s));
            w_cnt_nxt[s]  = r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
            w_ne_nxt[s]   = (w_cnt_nxt[s] != '0);
        end
    end

    // Outbound target: self ID and unmatched IDs go to the parent.
    always_comb begin
        w_dest = local_tx_data[DATA_WIDTH-1 -: DEST_WIDTH];
        w_hit  = (w_dest == FPGA_ID);
        w_tgt  = '0;
        for (int k = 0; k < NUM_GRID_LINKS; k++) begin
            if (!w_hit &&
                w_dest == GRID_DEST_IDS[DEST_WIDTH*k +: DEST_WIDTH]) begin
                w_hit = 1'b1;
                w_tgt = SW'(k + 1);
            end
        end
    end

    assign w_can = ~r_ov | w_oready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld           = '0;
        w_ld_data      = local_tx_data;
        local_tx_ready = 1'b0;
`ifdef GRID_ROUTER_BROADCAST_EN
        w_mask_nxt     = r_mask;
        w_bdata_nxt    = r_bdata;
`endif
        unique case (r_state)
            S_IDLE: begin
`ifdef GRID_ROUTER_BROADCAST_EN
                if (&w_dest) begin
                    local_tx_ready = &w_can;
                    if (local_tx_valid) begin
                        w_ld = w_can;
                        if (!(&w_can)) begin
                            w_mask_nxt  = w_can;
                            w_bdata_nxt = local_tx_data;
                            w_state_nxt = S_BCAST;
                        end
                    end
                end else
`endif
                begin
                    local_tx_ready = w_can[w_tgt];
                    if (local_tx_valid && w_can[w_tgt])
                        w_ld[w_tgt] = 1'b1;
                end
            end
            S_BCAST: begin
`ifdef GRID_ROUTER_BROADCAST_EN
                // The handler still holds the word; it is consumed in
                // the cycle the last pending link loads.
                w_ld_data  = r_bdata;
                w_ld       = w_can & ~r_mask;
                w_mask_nxt = r_mask | w_can;
                local_tx_ready = &(r_mask | w_can);
                if (&(r_mask | w_can)) begin
                    w_mask_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int o = 0; o < NS; o++) begin
            w_ov_nxt[o] = r_ov[o] && !w_oready[o];
            w_od_nxt[o] = r_od[o];
            if (w_ld[o]) begin
                w_ov_nxt[o] = 1'b1;
                w_od_nxt[o] = w_ld_data;
            end
        end
        w_busy_nxt = (|w_ne_nxt) || w_rx_valid_nxt || (|w_ov_nxt);
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NS; s++)
            if (w_push[s]) r_mem[s][r_wp[s]] <= w_in_data[s];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                r_wp[s]  <= '0;
                r_rp[s]  <= '0;
                r_cnt[s] <= '0;
                r_od[s]  <= '0;
            end
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_ptr      <= '0;
            r_ov       <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
`ifdef GRID_ROUTER_BROADCAST_EN
            r_mask     <= '0;
            r_bdata    <= '0;
`endif
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (w_push[s]) r_wp[s] <= r_wp[s] + 1'b1;
                if (w_pop[s])  r_rp[s] <= r_rp[s] + 1'b1;
                r_cnt[s] <= w_cnt_nxt[s];
                r_od[s]  <= w_od_nxt[s];
            end
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_ptr      <= w_ptr_nxt;
            r_ov       <= w_ov_nxt;
            r_busy     <= w_busy_nxt;
            r_state    <= w_state_nxt;
`ifdef GRID_ROUTER_BROADCAST_EN
            r_mask     <= w_mask_nxt;
            r_bdata    <= w_bdata_nxt;
`endif
        end
    end

    assign local_rx_valid = r_rx_valid;
    assign local_rx_data  = r_rx_data;
    assign router_busy    = r_busy;

endmodule

// File: tb/tb_grid_link_router.sv
// tb_grid_link_router: directed vectors and sequences for grid_link_router.
// Default parameters: 2 grid links (IDs 2,3), FPGA_ID 1, FIFO depth 8.
module tb_grid_link_router;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  local_tx_data;
    logic         local_tx_valid;
    logic         local_tx_ready;
    logic [63:0]  local_rx_data;
    logic         local_rx_valid;
    logic         local_rx_ready;
    logic [63:0]  parent_rx_data;
    logic         parent_rx_valid;
    logic         parent_rx_ready;
    logic [63:0]  parent_tx_data;
    logic         parent_tx_valid;
    logic         parent_tx_ready;
    logic [127:0] grid_in_data;
    logic [1:0]   grid_in_valid;
    logic [1:0]   grid_in_ready;
    logic [127:0] grid_out_data;
    logic [1:0]   grid_out_valid;
    logic [1:0]   grid_out_ready;
    logic         router_busy;

    always #5 clk = ~clk;

    grid_link_router dut (
        .clk             (clk),
        .reset           (reset),
        .local_tx_data   (local_tx_data),
        .local_tx_valid  (local_tx_valid),
        .local_tx_ready  (local_tx_ready),
        .local_rx_data   (local_rx_data),
        .local_rx_valid  (local_rx_valid),
        .local_rx_ready  (local_rx_ready),
        .parent_rx_data  (parent_rx_data),
        .parent_rx_valid (parent_rx_valid),
        .parent_rx_ready (parent_rx_ready),
        .parent_tx_data  (parent_tx_data),
        .parent_tx_valid (parent_tx_valid),
        .parent_tx_ready (parent_tx_ready),
        .grid_in_data    (grid_in_data),
        .grid_in_valid   (grid_in_valid),
        .grid_in_ready   (grid_in_ready),
        .grid_out_data   (grid_out_data),
        .grid_out_valid  (grid_out_valid),
        .grid_out_ready  (grid_out_ready),
        .router_busy     (router_busy)
    );

    typedef struct {
        logic [7:0]  dest;
        logic [55:0] body;
        logic [2:0]  mask;
    } ovec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        ovec_t       vt [6];
        logic [63:0] w;
        logic [63:0] mexp [12];
        logic [63:0] rxd;
        logic        hs;
        logic        rxhs;
        int          sent;
        int          rcv;

        vt[0] = '{8'd2,  56'h11, 3'b010};
        vt[1] = '{8'd3,  56'h22, 3'b100};
        vt[2] = '{8'd9,  56'h33, 3'b001};
        vt[3] = '{8'd1,  56'h44, 3'b001};
        vt[4] = '{8'd0,  56'h55, 3'b001};
`ifdef GRID_ROUTER_BROADCAST_EN
        vt[5] = '{8'hFF, 56'h66, 3'b111};
`else
        vt[5] = '{8'hFF, 56'h66, 3'b001};
`endif

        reset = 1'b1;
        local_tx_data = '0;  local_tx_valid = 1'b0;
        local_rx_ready = 1'b0;
        parent_rx_data = '0; parent_rx_valid = 1'b0;
        parent_tx_ready = 1'b1;
        grid_in_data = '0;   grid_in_valid = '0;
        grid_out_ready = 2'b11;
        tick; tick;
        reset = 1'b0;
        tick;

        chk("rst_rx_valid", 64'(local_rx_valid), 64'd0);
        chk("rst_rx_data", local_rx_data, 64'd0);
        chk("rst_ptx_valid", 64'(parent_tx_valid), 64'd0);
        chk("rst_gout_valid", 64'(grid_out_valid), 64'd0);
        chk("rst_prx_ready", 64'(parent_rx_ready), 64'd1);
        chk("rst_gin_ready", 64'(grid_in_ready), 64'd3);
        chk("rst_busy", 64'(router_busy), 64'd0);

        // Outbound routing table.
        for (int i = 0; i < 6; i++) begin
            w = {vt[i].dest, vt[i].body};
            local_tx_data  = w;
            local_tx_valid = 1'b1;
            #1;
            chk($sformatf("route%0d_ready", i), 64'(local_tx_ready), 64'd1);
            tick;
            local_tx_valid = 1'b0;
            chk($sformatf("route%0d_mask", i),
                64'({grid_out_valid, parent_tx_valid}), 64'(vt[i].mask));
            if (vt[i].mask[0])
                chk($sformatf("route%0d_pdata", i), parent_tx_data, w);
            if (vt[i].mask[1])
                chk($sformatf("route%0d_g0data", i), grid_out_data[63:0], w);
            if (vt[i].mask[2])
                chk($sformatf("route%0d_g1data", i), grid_out_data[127:64], w);
            tick;
        end

        // Outbound backpressure and per-link order.
        parent_tx_ready = 1'b0;
        local_tx_data  = {8'd9, 56'h1};
        local_tx_valid = 1'b1;
        #1;
        chk("bp_accept", 64'(local_tx_ready), 64'd1);
        tick;
        local_tx_data = {8'd9, 56'h2};
        #1;
        chk("bp_stall", 64'(local_tx_ready), 64'd0);
        tick;
        chk("bp_hold_data", parent_tx_data, {8'd9, 56'h1});
        parent_tx_ready = 1'b1;
        #1;
        chk("bp_release", 64'(local_tx_ready), 64'd1);
        tick;
        local_tx_valid = 1'b0;
        chk("bp_second", parent_tx_data, {8'd9, 56'h2});
        tick;
        chk("bp_drained", 64'(parent_tx_valid), 64'd0);

        // Round-robin merge, all three sources pushing 4 words.
        for (int r = 0; r < 4; r++) begin
            mexp[3*r]   = 64'h100 + 64'(r);
            mexp[3*r+1] = 64'h200 + 64'(r);
            mexp[3*r+2] = 64'h300 + 64'(r);
        end
        local_rx_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            parent_rx_valid = (c < 4);
            grid_in_valid   = (c < 4) ? 2'b11 : 2'b00;
            parent_rx_data  = 64'h100 + 64'(c);
            grid_in_data    = {64'h300 + 64'(c), 64'h200 + 64'(c)};
            tick;
            if (c == 0) begin
                chk("merge_lat1", 64'(local_rx_valid), 64'd0);
            end else begin
                chk($sformatf("merge%0d_valid", c), 64'(local_rx_valid), 64'd1);
                chk($sformatf("merge%0d_data", c), local_rx_data, mexp[c-1]);
            end
        end
        parent_rx_valid = 1'b0;
        grid_in_valid   = 2'b00;
        tick;
        chk("merge_end_valid", 64'(local_rx_valid), 64'd0);
        chk("merge_end_busy", 64'(router_busy), 64'd0);

        // FIFO fill on grid link 0 with the handler stalled.
        local_rx_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            grid_in_valid = (sent < 10) ? 2'b01 : 2'b00;
            grid_in_data  = {64'h0, 64'hA000 + 64'(sent)};
            hs = grid_in_valid[0] && grid_in_ready[0];
            tick;
            if (hs) sent++;
        end
        chk("fifo_accepted", 64'(sent), 64'd9);
        chk("fifo_full_ready", 64'(grid_in_ready[0]), 64'd0);
        chk("fifo_slot_valid", 64'(local_rx_valid), 64'd1);
        chk("fifo_slot_data", local_rx_data, 64'hA000);
        chk("fifo_busy", 64'(router_busy), 64'd1);

        local_rx_ready = 1'b1;
        rcv = 0;
        for (int c = 0; c < 40 && rcv < 10; c++) begin
            grid_in_valid = (sent < 10) ? 2'b01 : 2'b00;
            grid_in_data  = {64'h0, 64'hA000 + 64'(sent)};
            hs   = grid_in_valid[0] && grid_in_ready[0];
            rxhs = local_rx_valid && local_rx_ready;
            rxd  = local_rx_data;
            tick;
            if (hs) sent++;
            if (rxhs) begin
                chk($sformatf("fifo_order%0d", rcv), rxd, 64'hA000 + 64'(rcv));
                rcv++;
            end
        end
        chk("fifo_drain_count", 64'(rcv), 64'd10);
        grid_in_valid = 2'b00;
        tick;
        chk("fifo_drain_busy", 64'(router_busy), 64'd0);

        // Reset while words are buffered.
        local_rx_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            parent_rx_valid = 1'b1;
            parent_rx_data  = 64'hB000 + 64'(c);
            tick;
        end
        parent_rx_valid = 1'b0;
        chk("rst2_busy_before", 64'(router_busy), 64'd1);
        chk("rst2_slot_before", 64'(local_rx_valid), 64'd1);
        reset = 1'b1;
        tick;
        chk("rst2_rx_valid", 64'(local_rx_valid), 64'd0);
        chk("rst2_rx_data", local_rx_data, 64'd0);
        chk("rst2_busy", 64'(router_busy), 64'd0);
        chk("rst2_prx_ready", 64'(parent_rx_ready), 64'd1);
        reset = 1'b0;
        local_rx_ready = 1'b1;
        tick; tick;
        chk("rst2_no_replay", 64'(local_rx_valid), 64'd0);

`ifdef GRID_ROUTER_BROADCAST_EN
        // Broadcast with grid link 1 blocked.
        grid_out_ready = 2'b01;
        local_tx_data  = {8'd3, 56'h77};
        local_tx_valid = 1'b1;
        #1;
        chk("bc_pre_ready", 64'(local_tx_ready), 64'd1);
        tick;
        local_tx_data = {8'hFF, 56'hBB};
        #1;
        chk("bc_ready_low0", 64'(local_tx_ready), 64'd0);
        tick;
        chk("bc_parent_valid", 64'(parent_tx_valid), 64'd1);
        chk("bc_parent_data", parent_tx_data, {8'hFF, 56'hBB});
        chk("bc_g0_valid", 64'(grid_out_valid[0]), 64'd1);
        chk("bc_g0_data", grid_out_data[63:0], {8'hFF, 56'hBB});
        chk("bc_g1_old", grid_out_data[127:64], {8'd3, 56'h77});
        chk("bc_ready_low1", 64'(local_tx_ready), 64'd0);
        tick;
        chk("bc_ready_low2", 64'(local_tx_ready), 64'd0);
        chk("bc_no_reload", 64'({grid_out_valid[0], parent_tx_valid}), 64'd0);
        tick;
        grid_out_ready = 2'b11;
        #1;
        chk("bc_ready_done", 64'(local_tx_ready), 64'd1);
        tick;
        local_tx_valid = 1'b0;
        chk("bc_g1_valid", 64'(grid_out_valid[1]), 64'd1);
        chk("bc_g1_data", grid_out_data[127:64], {8'hFF, 56'hBB});
        tick;
        chk("bc_idle", 64'({grid_out_valid, parent_tx_valid}), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
